// File: rtl/controle_multiciclo_pkg.sv
// Shared types and encodings for the multicycle control unit of the 3-bit-opcode CPU.
package controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    INICIO  = 4'd0,
    BUSCA   = 4'd1,
    DECOD   = 4'd2,
    EXEC_R  = 4'd3,
    EXEC_I  = 4'd4,
    END_MEM = 4'd5,
    LE_MEM  = 4'd6,
    ESC_MEM = 4'd7,
    ESC_REG = 4'd8,
    DESVIO  = 4'd9,
    SALTO   = 4'd10,
    PARADO  = 4'd11,
    ERRO    = 4'd12
  } estado_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_LW   = 3'b001;
  localparam logic [2:0] OP_SW   = 3'b010;
  localparam logic [2:0] OP_BEQZ = 3'b011;
  localparam logic [2:0] OP_ADDI = 3'b100;
  localparam logic [2:0] OP_J    = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [1:0] ULAOP_ADD  = 2'b00;
  localparam logic [1:0] ULAOP_SUB  = 2'b01;
  localparam logic [1:0] ULAOP_RADD = 2'b10;
  localparam logic [1:0] ULAOP_ADDI = 2'b11;

  localparam logic [1:0] PCF_ULA   = 2'b00;
  localparam logic [1:0] PCF_SAIDA = 2'b01;
  localparam logic [1:0] PCF_SALTO = 2'b10;

  localparam logic [1:0] ULAB_REG  = 2'b00;
  localparam logic [1:0] ULAB_UM   = 2'b01;
  localparam logic [1:0] ULAB_IMM  = 2'b10;
  localparam logic [1:0] ULAB_ZERO = 2'b11;

  // States that hold a memory request and wait for MemPronta.
  function automatic logic eh_mem(estado_t e);
    return (e == BUSCA) || (e == LE_MEM) || (e == ESC_MEM);
  endfunction

endpackage

// File: rtl/controle_multiciclo_if.sv
// Control/status bundle between the multicycle controller and the datapath.
interface controle_multiciclo_if;
  logic [2:0] Opcode;
  logic       Zero;
  logic       MemPronta;
  logic       EscIR;
  logic       EscPC;
  logic [1:0] PCFonte;
  logic       IouD;
  logic       LerMem;
  logic       EscMem;
  logic [1:0] ULAOp;
  logic       ULAFonteA;
  logic [1:0] ULAFonteB;
  logic       SelDest;
  logic       RegFonte;
  logic       EscReg;
  logic       Parado;
  logic       Erro;
  logic [3:0] Estado;

  modport master (
    input  Opcode, Zero, MemPronta,
    output EscIR, EscPC, PCFonte, IouD, LerMem, EscMem, ULAOp, ULAFonteA, ULAFonteB,
           SelDest, RegFonte, EscReg, Parado, Erro, Estado
  );

  modport slave (
    output Opcode, Zero, MemPronta,
    input  EscIR, EscPC, PCFonte, IouD, LerMem, EscMem, ULAOp, ULAFonteA, ULAFonteB,
           SelDest, RegFonte, EscReg, Parado, Erro, Estado
  );
endinterface

// File: rtl/controle_multiciclo_contador_espera.sv
// Memory wait counter: flags the cycle whose increment would reach TIMEOUT.
module controle_multiciclo_contador_espera #(
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expirou
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expirou = en && !clr && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM: sequences fetch, decode, execute, memory and writeback steps.
module controle_multiciclo
  import controle_multiciclo_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  controle_multiciclo_if.master  bus
);

  estado_t    estado_q, estado_d;
  logic       cnt_en, cnt_clr, expirou;
  logic       esc_ir, esc_pc, iou_d, ler_mem, esc_mem, ula_a, sel_dest, reg_fonte, esc_reg;
  logic       parado, erro;
  logic [1:0] pc_fonte, ula_op, ula_b;

  // Counter runs only while a request is outstanding; any other cycle clears it.
  assign cnt_en  = eh_mem(estado_q) && !bus.MemPronta;
  assign cnt_clr = !cnt_en;

  controle_multiciclo_contador_espera #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_contador (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .expirou (expirou)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= INICIO;
    end else begin
      estado_q <= estado_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    esc_ir    = 1'b0;
    esc_pc    = 1'b0;
    pc_fonte  = PCF_ULA;
    iou_d     = 1'b0;
    ler_mem   = 1'b0;
    esc_mem   = 1'b0;
    ula_op    = ULAOP_ADD;
    ula_a     = 1'b0;
    ula_b     = ULAB_REG;
    sel_dest  = 1'b0;
    reg_fonte = 1'b0;
    esc_reg   = 1'b0;
    parado    = 1'b0;
    erro      = 1'b0;
    case (estado_q)
      INICIO: estado_d = BUSCA;
      BUSCA: begin
        ler_mem = 1'b1;
        ula_b   = ULAB_UM;
        if (bus.MemPronta) begin
          esc_ir   = 1'b1;
          esc_pc   = 1'b1;
          estado_d = DECOD;
        end else if (expirou) begin
          estado_d = ERRO;
        end
      end
      DECOD: begin
        ula_b = ULAB_IMM;
        unique case (bus.Opcode)
          OP_ADD, OP_SUB: estado_d = EXEC_R;
          OP_LW, OP_SW:   estado_d = END_MEM;
          OP_BEQZ:        estado_d = DESVIO;
          OP_ADDI:        estado_d = EXEC_I;
          OP_J:           estado_d = SALTO;
          default:        estado_d = PARADO;
        endcase
      end
      EXEC_R: begin
        ula_a    = 1'b1;
        ula_b    = ULAB_REG;
        ula_op   = (bus.Opcode == OP_SUB) ? ULAOP_SUB : ULAOP_RADD;
        estado_d = ESC_REG;
      end
      EXEC_I: begin
        ula_a    = 1'b1;
        ula_b    = ULAB_IMM;
        ula_op   = ULAOP_ADDI;
        estado_d = ESC_REG;
      end
      END_MEM: begin
        ula_a    = 1'b1;
        ula_b    = ULAB_IMM;
        estado_d = (bus.Opcode == OP_LW) ? LE_MEM : ESC_MEM;
      end
      LE_MEM: begin
        iou_d   = 1'b1;
        ler_mem = 1'b1;
        if (bus.MemPronta)  estado_d = ESC_REG;
        else if (expirou)   estado_d = ERRO;
      end
      ESC_MEM: begin
        iou_d   = 1'b1;
        esc_mem = 1'b1;
        if (bus.MemPronta)  estado_d = BUSCA;
        else if (expirou)   estado_d = ERRO;
      end
      ESC_REG: begin
        esc_reg   = 1'b1;
        sel_dest  = (bus.Opcode == OP_LW);
        reg_fonte = (bus.Opcode == OP_LW);
        estado_d  = BUSCA;
      end
      DESVIO: begin
        ula_a    = 1'b1;
        ula_b    = ULAB_ZERO;
        ula_op   = ULAOP_SUB;
        esc_pc   = bus.Zero;
        pc_fonte = PCF_SAIDA;
        estado_d = BUSCA;
      end
      SALTO: begin
        esc_pc   = 1'b1;
        pc_fonte = PCF_SALTO;
        estado_d = BUSCA;
      end
      PARADO:  parado = 1'b1;
      ERRO:    erro   = 1'b1;
      default: estado_d = INICIO;
    endcase
  end

  assign bus.EscIR     = esc_ir;
  assign bus.EscPC     = esc_pc;
  assign bus.PCFonte   = pc_fonte;
  assign bus.IouD      = iou_d;
  assign bus.LerMem    = ler_mem;
  assign bus.EscMem    = esc_mem;
  assign bus.ULAOp     = ula_op;
  assign bus.ULAFonteA = ula_a;
  assign bus.ULAFonteB = ula_b;
  assign bus.SelDest   = sel_dest;
  assign bus.RegFonte  = reg_fonte;
  assign bus.EscReg    = esc_reg;
  assign bus.Parado    = parado;
  assign bus.Erro      = erro;
  assign bus.Estado    = estado_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench: per-instruction cycle templates feed expected outputs to a negedge monitor.
module tb_controle_multiciclo;
  import controle_multiciclo_pkg::*;

  localparam int unsigned TIMEOUT = 15;

  typedef struct packed {
    logic       esc_ir;
    logic       esc_pc;
    logic [1:0] pc_fonte;
    logic       iou_d;
    logic       ler_mem;
    logic       esc_mem;
    logic [1:0] ula_op;
    logic       ula_a;
    logic [1:0] ula_b;
    logic       sel_dest;
    logic       reg_fonte;
    logic       esc_reg;
    logic       parado;
    logic       erro;
    logic [3:0] estado;
  } out_t;

  typedef struct packed {
    logic [2:0] op;
    logic       zero;
    logic       mp;
    out_t       e;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controle_multiciclo_if bus ();

  controle_multiciclo #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  out_t act;
  assign act = {bus.EscIR, bus.EscPC, bus.PCFonte, bus.IouD, bus.LerMem, bus.EscMem, bus.ULAOp,
                bus.ULAFonteA, bus.ULAFonteB, bus.SelDest, bus.RegFonte, bus.EscReg, bus.Parado,
                bus.Erro, bus.Estado};

  cyc_t plan[$];
  out_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] x);
    n_checks++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, a, x);
    end
  endtask

  always @(negedge clk) begin
    out_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("ciclo estado=%0d", e.estado), 32'(act), 32'(e));
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic out_t em(estado_t s);
    out_t e;
    e = '0;
    e.estado = s;
    return e;
  endfunction

  task automatic add(input logic [2:0] op, input logic z, input logic mp, input out_t e);
    cyc_t c;
    c.op = op;
    c.zero = z;
    c.mp = mp;
    c.e = e;
    plan.push_back(c);
  endtask

  // Fetch: request held for w idle cycles, then IR and PC load in the ready cycle.
  task automatic fetch(input int w);
    out_t e;
    e = em(BUSCA);
    e.ler_mem = 1'b1;
    e.ula_b = 2'b01;
    for (int i = 0; i < w; i++) add(rop(), rb(), 1'b0, e);
    e.esc_ir = 1'b1;
    e.esc_pc = 1'b1;
    add(rop(), rb(), 1'b1, e);
  endtask

  task automatic fetch_timeout(input int n_erro);
    out_t e;
    e = em(BUSCA);
    e.ler_mem = 1'b1;
    e.ula_b = 2'b01;
    for (int i = 0; i < int'(TIMEOUT); i++) add(rop(), rb(), 1'b0, e);
    e = em(ERRO);
    e.erro = 1'b1;
    for (int i = 0; i < n_erro; i++) add(rop(), rb(), rb(), e);
  endtask

  // One whole instruction; cut stops a memory access after its wait cycles.
  task automatic instr(input logic [2:0] op, input logic z, input int wf, input int wm,
                       input int n_halt, input logic cut);
    out_t e;
    fetch(wf);
    e = em(DECOD);
    e.ula_b = 2'b10;
    add(op, rb(), rb(), e);
    case (op)
      3'b000, 3'b110, 3'b100: begin
        e = em(op == 3'b100 ? EXEC_I : EXEC_R);
        e.ula_a = 1'b1;
        e.ula_b = (op == 3'b100) ? 2'b10 : 2'b00;
        e.ula_op = (op == 3'b100) ? 2'b11 : (op == 3'b110) ? 2'b01 : 2'b10;
        add(op, rb(), rb(), e);
        e = em(ESC_REG);
        e.esc_reg = 1'b1;
        add(op, rb(), rb(), e);
      end
      3'b001, 3'b010: begin
        e = em(END_MEM);
        e.ula_a = 1'b1;
        e.ula_b = 2'b10;
        add(op, rb(), rb(), e);
        e = em(op == 3'b001 ? LE_MEM : ESC_MEM);
        e.iou_d = 1'b1;
        e.ler_mem = (op == 3'b001);
        e.esc_mem = (op == 3'b010);
        for (int i = 0; i < wm; i++) add(op, rb(), 1'b0, e);
        if (!cut) begin
          add(op, rb(), 1'b1, e);
          if (op == 3'b001) begin
            e = em(ESC_REG);
            e.esc_reg = 1'b1;
            e.sel_dest = 1'b1;
            e.reg_fonte = 1'b1;
            add(op, rb(), rb(), e);
          end
        end
      end
      3'b011: begin
        e = em(DESVIO);
        e.ula_a = 1'b1;
        e.ula_b = 2'b11;
        e.ula_op = 2'b01;
        e.pc_fonte = 2'b01;
        e.esc_pc = z;
        add(op, z, rb(), e);
      end
      3'b101: begin
        e = em(SALTO);
        e.esc_pc = 1'b1;
        e.pc_fonte = 2'b10;
        add(op, rb(), rb(), e);
      end
      default: begin
        e = em(PARADO);
        e.parado = 1'b1;
        for (int i = 0; i < n_halt; i++) add(op, rb(), rb(), e);
      end
    endcase
  endtask

  // Called at posedge+1; each entry occupies one clock cycle.
  task automatic play();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      bus.Opcode = c.op;
      bus.Zero = c.zero;
      bus.MemPronta = c.mp;
      sb.push_back(c.e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic async_reset(input string name);
    bus.MemPronta = 1'b0;
    #2 rst_n = 1'b0;
    #1 check({name, " assincrono"}, 32'(act), 32'(em(INICIO)));
    @(posedge clk);
    #1 check({name, " mantido"}, 32'(act), 32'(em(INICIO)));
  endtask

  task automatic reset_release();
    @(posedge clk);
    #1 rst_n = 1'b1;
    add(rop(), rb(), rb(), em(INICIO));
  endtask

  initial begin
    bus.Opcode = 3'b000;
    bus.Zero = 1'b0;
    bus.MemPronta = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset", 32'(act), 32'(em(INICIO)));

    reset_release();
    instr(3'b000, 1'b0, 0, 0, 0, 1'b0);
    instr(3'b001, 1'b0, 0, 3, 0, 1'b0);
    instr(3'b011, 1'b1, 0, 0, 0, 1'b0);
    instr(3'b011, 1'b0, 2, 0, 0, 1'b0);
    instr(3'b000, 1'b0, TIMEOUT - 1, 0, 0, 1'b0);
    instr(3'b001, 1'b0, 1, TIMEOUT - 1, 0, 1'b0);
    instr(3'b010, 1'b0, 0, TIMEOUT - 1, 0, 1'b0);
    play();

    for (int k = 0; k < 60; k++) begin
      instr(3'($urandom_range(0, 6)), rb(), $urandom_range(0, 4), $urandom_range(0, 4), 0, 1'b0);
      play();
    end

    instr(3'b111, 1'b0, 1, 0, 20, 1'b0);
    play();
    async_reset("reset em PARADO");

    reset_release();
    instr(3'b010, 1'b0, 0, 2, 0, 1'b1);
    play();
    async_reset("reset em ESC_MEM");

    reset_release();
    instr(3'b101, 1'b0, 0, 0, 0, 1'b0);
    fetch_timeout(5);
    play();

    @(negedge clk);
    check("scoreboard vazio", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
